adder_arbiter: RTL

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/adder_arbiter.sv
// Two-port arbiter in front of an external 32-bit adder.
// Grants one requester, drives the adder, captures the sum.
module adder_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  input  logic        cin0,
  input  logic        cin1,
  output logic        gnt0,
  output logic        gnt1,
  output logic [31:0] add_x,
  output logic [31:0] add_y,
  output logic        add_cin,
  input  logic [31:0] add_s,
  input  logic        add_cout,
  output logic [31:0] res,
  output logic        res_cout,
  output logic        res_ovf,
  output logic        res_valid,
  output logic        res_id,
  output logic        busy,
  output logic [15:0] op_count
);

  typedef enum logic {
    IDLE,
    EXEC
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [31:0] x_q;
  logic [31:0] y_q;
  logic        cin_q;
  logic        owner;
  logic        last_owner;
  logic        any_req;
  logic        win;

  assign add_x   = x_q;
  assign add_y   = y_q;
  assign add_cin = cin_q;
  assign busy    = (state == EXEC);
  assign any_req = req0 | req1;

  // pick the winning port; ties alternate unless fixed priority
  always_comb begin
    win = 1'b0;
    unique case (1'b1)
      (req0 & ~req1): win = 1'b0;
      (~req0 & req1): win = 1'b1;
      (req0 & req1):  win = RR_EN ? ~last_owner : 1'b0;
      default:        win = 1'b0;
    endcase
  end

  // next state: one grant cycle, then one capture cycle
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (any_req) state_nx = EXEC;
      EXEC: state_nx = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // grant pulse and operand capture for the winner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      cin_q      <= 1'b0;
      owner      <= 1'b0;
      last_owner <= 1'b1;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      if (state == IDLE && any_req) begin
        x_q        <= win ? a1 : a0;
        y_q        <= win ? b1 : b0;
        cin_q      <= win ? cin1 : cin0;
        owner      <= win;
        last_owner <= win;
        gnt0       <= ~win;
        gnt1       <= win;
      end
    end
  end

  // result capture; values hold until the next completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res       <= '0;
      res_cout  <= 1'b0;
      res_ovf   <= 1'b0;
      res_id    <= 1'b0;
      res_valid <= 1'b0;
      op_count  <= '0;
    end else begin
      res_valid <= 1'b0;
      if (state == EXEC) begin
        res       <= add_s;
        res_cout  <= add_cout;
        res_ovf   <= (x_q[31] == y_q[31]) && (add_s[31] != x_q[31]);
        res_id    <= owner;
        res_valid <= 1'b1;
        op_count  <= op_count + 16'd1;
      end
    end
  end

endmodule
